// File: rtl/line_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// line_cmd_arbiter : round-robin arbiter, optional burst lock, feeding one
//                    registered command into the line_drawer rts/rtr input.
// Revision 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module line_cmd_arbiter #(
   parameter int N_REQ     = 4,
   parameter int IDX_W     = 2,
   parameter int MAX_BURST = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req_rts,
   output logic [N_REQ-1:0]    req_rtr,
   input  logic [N_REQ-1:0]    req_lock,
   input  logic [N_REQ*10-1:0] req_x1,
   input  logic [N_REQ*10-1:0] req_y1,
   input  logic [N_REQ*10-1:0] req_x2,
   input  logic [N_REQ*10-1:0] req_y2,
   input  logic [N_REQ*12-1:0] req_color,
   output logic                ld_rts,
   input  logic                ld_rtr,
   output logic [9:0]          ld_x1,
   output logic [9:0]          ld_y1,
   output logic [9:0]          ld_x2,
   output logic [9:0]          ld_y2,
   output logic [11:0]         ld_color,
   output logic [IDX_W-1:0]    ld_owner,
   output logic                busy
);

   typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic             lock_vld_q, lock_vld_d;
   logic [7:0]       burst_cnt_q, burst_cnt_d;
   logic [9:0]       ld_x1_q, ld_x1_d, ld_y1_q, ld_y1_d;
   logic [9:0]       ld_x2_q, ld_x2_d, ld_y2_q, ld_y2_d;
   logic [11:0]      ld_color_q, ld_color_d;
   logic [IDX_W-1:0] ld_owner_q, ld_owner_d;

   logic [N_REQ-1:0] w_req_hi;
   logic             w_owner_rts;
   logic             w_lock_hit;
   logic [IDX_W-1:0] w_win;
   logic             w_win_lock;
   logic [9:0]       w_x1, w_y1, w_x2, w_y2;
   logic [11:0]      w_color;
   logic [7:0]       w_burst_new;

   // Winner: the lock owner if it is still requesting, otherwise the first
   // requester at or above rr_ptr, wrapping to the lowest requester.
   always_comb begin
      w_owner_rts = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         w_req_hi[i] = req_rts[i] & (IDX_W'(i) >= rr_ptr_q);
         if (ld_owner_q == IDX_W'(i)) w_owner_rts = req_rts[i];
      end
      w_lock_hit = lock_vld_q & w_owner_rts;

      w_win = '0;
      if (w_lock_hit) begin
         w_win = ld_owner_q;
      end else if (|w_req_hi) begin
         for (int i = N_REQ-1; i >= 0; i--)
            if (w_req_hi[i]) w_win = IDX_W'(i);
      end else begin
         for (int i = N_REQ-1; i >= 0; i--)
            if (req_rts[i]) w_win = IDX_W'(i);
      end

      w_x1 = '0; w_y1 = '0; w_x2 = '0; w_y2 = '0; w_color = '0; w_win_lock = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_win == IDX_W'(i)) begin
            w_x1       = req_x1[10*i +: 10];
            w_y1       = req_y1[10*i +: 10];
            w_x2       = req_x2[10*i +: 10];
            w_y2       = req_y2[10*i +: 10];
            w_color    = req_color[12*i +: 12];
            w_win_lock = req_lock[i];
         end
      end
      w_burst_new = w_lock_hit ? burst_cnt_q + 8'd1 : 8'd1;
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      lock_vld_d  = lock_vld_q;
      burst_cnt_d = burst_cnt_q;
      ld_x1_d     = ld_x1_q;
      ld_y1_d     = ld_y1_q;
      ld_x2_d     = ld_x2_q;
      ld_y2_d     = ld_y2_q;
      ld_color_d  = ld_color_q;
      ld_owner_d  = ld_owner_q;
      req_rtr     = '0;
      case (state_q)
         IDLE: begin
            if (lock_vld_q && !w_owner_rts) begin
               lock_vld_d  = 1'b0;
               burst_cnt_d = 8'd0;
            end
            if (|req_rts) begin
               req_rtr     = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
               ld_x1_d     = w_x1;
               ld_y1_d     = w_y1;
               ld_x2_d     = w_x2;
               ld_y2_d     = w_y2;
               ld_color_d  = w_color;
               ld_owner_d  = w_win;
               rr_ptr_d    = (w_win == IDX_W'(N_REQ-1)) ? '0 : w_win + IDX_W'(1);
               burst_cnt_d = w_burst_new;
               lock_vld_d  = w_win_lock & (w_burst_new < 8'(MAX_BURST));
               state_d     = SEND;
            end
         end
         SEND: begin
            if (ld_rtr) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         lock_vld_q  <= 1'b0;
         burst_cnt_q <= 8'd0;
         ld_x1_q     <= '0;
         ld_y1_q     <= '0;
         ld_x2_q     <= '0;
         ld_y2_q     <= '0;
         ld_color_q  <= '0;
         ld_owner_q  <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         lock_vld_q  <= lock_vld_d;
         burst_cnt_q <= burst_cnt_d;
         ld_x1_q     <= ld_x1_d;
         ld_y1_q     <= ld_y1_d;
         ld_x2_q     <= ld_x2_d;
         ld_y2_q     <= ld_y2_d;
         ld_color_q  <= ld_color_d;
         ld_owner_q  <= ld_owner_d;
      end
   end

   assign ld_rts   = (state_q == SEND);
   assign busy     = (state_q == SEND) | lock_vld_q;
   assign ld_x1    = ld_x1_q;
   assign ld_y1    = ld_y1_q;
   assign ld_x2    = ld_x2_q;
   assign ld_y2    = ld_y2_q;
   assign ld_color = ld_color_q;
   assign ld_owner = ld_owner_q;

endmodule

`default_nettype wire

// File: tb/tb_line_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_line_cmd_arbiter : scenario tasks plus a transfer scoreboard for
//                       line_cmd_arbiter (N_REQ=4, MAX_BURST=3).
// Revision 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_line_cmd_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_rts, req_rtr, req_lock;
   logic [39:0] req_x1, req_y1, req_x2, req_y2;
   logic [47:0] req_color;
   logic        ld_rts, ld_rtr, busy;
   logic [9:0]  ld_x1, ld_y1, ld_x2, ld_y2;
   logic [11:0] ld_color;
   logic [1:0]  ld_owner;

   logic [9:0]  fx1 [4], fy1 [4], fx2 [4], fy2 [4];
   logic [11:0] fcol [4];

   typedef struct packed {
      logic [9:0]  x1, y1, x2, y2;
      logic [11:0] c;
      logic [1:0]  o;
   } cmd_t;

   cmd_t sb[$];
   cmd_t exp_c;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         req_x1[10*i +: 10]    = fx1[i];
         req_y1[10*i +: 10]    = fy1[i];
         req_x2[10*i +: 10]    = fx2[i];
         req_y2[10*i +: 10]    = fy2[i];
         req_color[12*i +: 12] = fcol[i];
      end
   end

   line_cmd_arbiter #(.N_REQ(4), .IDX_W(2), .MAX_BURST(3)) dut (
      .clk(clk), .rst(rst),
      .req_rts(req_rts), .req_rtr(req_rtr), .req_lock(req_lock),
      .req_x1(req_x1), .req_y1(req_y1), .req_x2(req_x2), .req_y2(req_y2),
      .req_color(req_color),
      .ld_rts(ld_rts), .ld_rtr(ld_rtr),
      .ld_x1(ld_x1), .ld_y1(ld_y1), .ld_x2(ld_x2), .ld_y2(ld_y2),
      .ld_color(ld_color), .ld_owner(ld_owner), .busy(busy)
   );

   // Every line_drawer transfer must match the oldest expected command.
   always @(negedge clk) begin
      if (!rst && ld_rts && ld_rtr) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL xfer_unexpected: got owner %0d, expected no transfer", ld_owner);
         end else begin
            exp_c = sb.pop_front();
            if ({ld_x1, ld_y1, ld_x2, ld_y2, ld_color, ld_owner} !== exp_c) begin
               failures++;
               $display("FAIL xfer_cmd: got %h expected %h",
                        {ld_x1, ld_y1, ld_x2, ld_y2, ld_color, ld_owner}, exp_c);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int o);
      sb.push_back({fx1[o], fy1[o], fx2[o], fy2[o], fcol[o], 2'(o)});
   endtask

   task automatic set_default_fields();
      for (int i = 0; i < 4; i++) begin
         fx1[i]  = 10'(i*100 + 1);
         fy1[i]  = 10'(i*100 + 2);
         fx2[i]  = 10'(i*100 + 3);
         fy2[i]  = 10'(i*100 + 4);
         fcol[i] = 12'(i*256 + 171);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; req_rts = '0; req_lock = '0; ld_rtr = 1'b0;
      set_default_fields();
      cyc(); cyc();
      rst = 1'b0;
   endtask

   task automatic check_sb_empty(input string name);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL %s: got %0d pending commands, expected 0", name, sb.size());
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if ({ld_rts, req_rtr, busy} !== 6'b0) begin
         failures++;
         $display("FAIL reset_ctl: got %b expected 000000", {ld_rts, req_rtr, busy});
      end
      checks++;
      if ({ld_x1, ld_y1, ld_x2, ld_y2, ld_color, ld_owner} !== 54'h0) begin
         failures++;
         $display("FAIL reset_fields: got %h expected 0",
                  {ld_x1, ld_y1, ld_x2, ld_y2, ld_color, ld_owner});
      end
   endtask

   task automatic test_single();
      do_reset();
      fx1[2] = 10'd3; fy1[2] = 10'd5; fx2[2] = 10'd40; fy2[2] = 10'd9; fcol[2] = 12'hF00;
      req_rts = 4'b0100; ld_rtr = 1'b1;
      push_exp(2);
      @(negedge clk);
      checks++;
      if (req_rtr !== 4'b0100) begin
         failures++; $display("FAIL single_rtr: got %b expected 0100", req_rtr);
      end
      cyc();
      req_rts = '0;
      @(negedge clk);
      checks++;
      if ({ld_rts, ld_x1, ld_y2, ld_color, ld_owner, req_rtr} !==
          {1'b1, 10'd3, 10'd9, 12'hF00, 2'd2, 4'b0000}) begin
         failures++;
         $display("FAIL single_send: got rts=%b x1=%0d y2=%0d col=%h own=%0d rtr=%b expected 1 3 9 f00 2 0000",
                  ld_rts, ld_x1, ld_y2, ld_color, ld_owner, req_rtr);
      end
      cyc();
      @(negedge clk);
      checks++;
      if (ld_rts !== 1'b0) begin
         failures++; $display("FAIL single_idle: got ld_rts=%b expected 0", ld_rts);
      end
      check_sb_empty("single_done");
   endtask

   task automatic test_round_robin();
      int order [6] = '{0, 1, 2, 3, 0, 1};
      do_reset();
      req_rts = 4'b1111; ld_rtr = 1'b1;
      for (int k = 0; k < 6; k++) push_exp(order[k]);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checks++;
         if (req_rtr !== 4'(1 << order[k])) begin
            failures++;
            $display("FAIL rr_grant%0d: got %b expected %b", k, req_rtr, 4'(1 << order[k]));
         end
         cyc();
         if (k == 5) req_rts = '0;
         @(negedge clk);
         checks++;
         if ({ld_rts, req_rtr} !== 5'b10000) begin
            failures++;
            $display("FAIL rr_send%0d: got %b expected 10000", k, {ld_rts, req_rtr});
         end
         cyc();
      end
      check_sb_empty("rr_done");
   endtask

   task automatic test_back_pressure();
      do_reset();
      req_rts = 4'b0001; ld_rtr = 1'b0;
      push_exp(0);
      @(negedge clk);
      checks++;
      if (req_rtr !== 4'b0001) begin
         failures++; $display("FAIL bp_rtr: got %b expected 0001", req_rtr);
      end
      cyc();
      req_rts = 4'b1110;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checks++;
         if ({ld_rts, ld_x1, ld_y1, ld_color, ld_owner, req_rtr} !==
             {1'b1, 10'd1, 10'd2, 12'd171, 2'd0, 4'b0000}) begin
            failures++;
            $display("FAIL bp_hold%0d: got rts=%b x1=%0d y1=%0d col=%h own=%0d rtr=%b expected 1 1 2 0ab 0 0000",
                     k, ld_rts, ld_x1, ld_y1, ld_color, ld_owner, req_rtr);
         end
         cyc();
      end
      ld_rtr = 1'b1; req_rts = '0;
      cyc();
      @(negedge clk);
      checks++;
      if (ld_rts !== 1'b0) begin
         failures++; $display("FAIL bp_release: got ld_rts=%b expected 0", ld_rts);
      end
      cyc(); cyc();
      check_sb_empty("bp_done");
   endtask

   task automatic test_burst_lock();
      int   order [5] = '{1, 1, 1, 2, 0};
      logic bsy   [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      do_reset();
      req_rts = 4'b0010; req_lock = 4'b0010; ld_rtr = 1'b1;
      for (int k = 0; k < 5; k++) push_exp(order[k]);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if ({req_rtr, busy} !== {4'(1 << order[k]), bsy[k]}) begin
            failures++;
            $display("FAIL burst_grant%0d: got rtr=%b busy=%b expected %b %b",
                     k, req_rtr, busy, 4'(1 << order[k]), bsy[k]);
         end
         cyc();
         if (k == 0) req_rts = 4'b0111;
         if (k == 4) req_rts = '0;
         @(negedge clk);
         checks++;
         if ({ld_rts, busy} !== 2'b11) begin
            failures++; $display("FAIL burst_send%0d: got %b expected 11", k, {ld_rts, busy});
         end
         cyc();
      end
      req_lock = '0;
      check_sb_empty("burst_done");
   endtask

   task automatic test_lock_release();
      do_reset();
      req_rts = 4'b1000; req_lock = 4'b1000; ld_rtr = 1'b1;
      push_exp(3); push_exp(0);
      @(negedge clk);
      checks++;
      if (req_rtr !== 4'b1000) begin
         failures++; $display("FAIL rel_first: got %b expected 1000", req_rtr);
      end
      cyc();
      req_rts = 4'b0001; req_lock = '0;
      cyc();
      @(negedge clk);
      checks++;
      if (req_rtr !== 4'b0001) begin
         failures++; $display("FAIL rel_same_cycle: got %b expected 0001", req_rtr);
      end
      cyc();
      req_rts = '0;
      cyc();
      @(negedge clk);
      checks++;
      if ({ld_rts, busy} !== 2'b00) begin
         failures++; $display("FAIL rel_unlocked: got %b expected 00", {ld_rts, busy});
      end
      check_sb_empty("rel_done");
   endtask

   task automatic test_reset_mid_send();
      do_reset();
      req_rts = 4'b0100; ld_rtr = 1'b0;
      cyc();
      req_rts = 4'b1111;
      @(negedge clk);
      checks++;
      if ({ld_rts, ld_owner} !== 3'b110) begin
         failures++; $display("FAIL rms_send: got %b expected 110", {ld_rts, ld_owner});
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0; ld_rtr = 1'b1;
      push_exp(0);
      @(negedge clk);
      checks++;
      if ({ld_rts, ld_x1, ld_y1, ld_x2, ld_y2, ld_color, ld_owner} !== 55'h0) begin
         failures++;
         $display("FAIL rms_cleared: got %h expected 0",
                  {ld_rts, ld_x1, ld_y1, ld_x2, ld_y2, ld_color, ld_owner});
      end
      checks++;
      if (req_rtr !== 4'b0001) begin
         failures++; $display("FAIL rms_first_winner: got %b expected 0001", req_rtr);
      end
      cyc();
      req_rts = '0;
      cyc();
      check_sb_empty("rms_done");
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_back_pressure();
      test_burst_lock();
      test_lock_release();
      test_reset_mid_send();
      cyc(); cyc();
      check_sb_empty("final");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/line_cmd_arbiter.md
Name: line_cmd_arbiter

Overview:
- Shares one line_drawer command input between N_REQ requesters, e.g. the UI overlay, the shape sequencer and the host register port.
- Arbitration is round-robin. An optional burst lock lets one requester issue a run of consecutive lines, such as a polyline, without interleaving from other requesters.
- The winning command is registered and presented to the line_drawer input handshake (rts/rtr), together with the owner index.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- IDX_W, 2, owner index width; must be ≥ clog2(N_REQ).
- MAX_BURST, 8, maximum consecutive grants under lock (1..255). A value of 1 disables locking.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- req_rts  in  N_REQ  per-requester command valid.
- req_rtr  out  N_REQ  per-requester accept; at most one bit high.
- req_lock  in  N_REQ  per-requester burst-lock request; sampled with the command.
- req_x1, req_y1, req_x2, req_y2  in  N_REQ*10 each  packed endpoints; requester i occupies bits [10i+9:10i].
- req_color  in  N_REQ*12  packed colours; requester i occupies bits [12i+11:12i].
- ld_rts  out  1  command valid toward line_drawer in_rts.
- ld_rtr  in  1  line_drawer in_rtr.
- ld_x1, ld_y1, ld_x2, ld_y2  out  10 each  registered command endpoints.
- ld_color  out  12  registered command colour.
- ld_owner  out  IDX_W  index of the requester whose command is on ld_*.
- busy  out  1  high when in SEND or when the lock is held.

Behaviour:
- Reset values (rst=1 at a clk edge):
  - state=IDLE; ld_rts=0; req_rtr=0.
  - ld_x1/ld_y1/ld_x2/ld_y2/ld_color/ld_owner=0.
  - rr_ptr=0; lock_vld=0; burst_cnt=0; busy=0.
- Reset mid-SEND discards the held command; no accept is re-issued to its requester.
- Transfers: req_xfc[i] = req_rts[i] & req_rtr[i]; ld_xfc = ld_rts & ld_rtr.
- States:
  - IDLE: ld_rts=0. req_rtr is combinational and one-hot to the winner w, and only if some req_rts is high. On req_xfc[w], capture w's fields into ld_*, set ld_owner<=w, and go to SEND.
  - SEND: ld_rts=1 and req_rtr=0. ld_* must hold stable until ld_xfc. On ld_xfc, go to IDLE.
- Winner selection in IDLE:
  - Lock grant: if lock_vld=1 and req_rts[ld_owner]=1, then w=ld_owner.
  - Lock release: if lock_vld=1 and req_rts[ld_owner]=0, clear lock_vld and burst_cnt that cycle and use round-robin in the same cycle.
  - Round-robin: first i with req_rts[i]=1, scanning rr_ptr, rr_ptr+1, … mod N_REQ.
- On every grant:
  - rr_ptr <= (w+1) mod N_REQ. This also applies under lock, so the requester after the owner wins after release.
  - Same owner as the previous grant while locked: burst_cnt <= burst_cnt+1. Otherwise burst_cnt <= 1.
  - lock_vld <= req_lock[w] & (new burst_cnt < MAX_BURST). Reaching MAX_BURST forces release.
- Latency:
  - req_xfc in cycle t gives ld_rts=1 in cycle t+1.
  - Minimum spacing is 2 cycles per command: the IDLE cycle plus at least one SEND cycle.
- Only one command is in flight. No internal FIFO.
- No combinational path from ld_rtr to req_rtr: req_rtr depends only on state, req_rts, rr_ptr, lock_vld, ld_owner.
- Requesters must hold their fields stable while req_rts=1 and not accepted.
- Ports of index ≥ N_REQ do not exist; the rr_ptr wrap uses N_REQ, not 2^IDX_W.

Test Plan:
1. Single requester. N_REQ=4, req_rts=0100, cmd (3,5)-(40,9), colour 0xF00, ld_rtr=1 → req_rtr=0100 for 1 cycle. Next cycle ld_rts=1, ld_x1=3, ld_y2=9, ld_color=0xF00, ld_owner=2. Then back to IDLE.
2. Round-robin fairness. All four req_rts held high, no lock, ld_rtr=1 → grant order 0,1,2,3,0,1; one grant every 2 cycles.
3. Back-pressure. ld_rtr=0 for 10 cycles after SEND entry → ld_rts held at 1 and ld_* unchanged; req_rtr=0000 throughout. ld_rtr=1 → exactly one ld_xfc.
4. Burst lock. MAX_BURST=3; req 1 holds lock and rts; reqs 0 and 2 requesting → grants 1,1,1,2,0. busy stays high through the lock.
5. Lock release on idle owner. Req 3 locked, then drops req_rts while req 0 is requesting → req 0 granted in that same IDLE cycle; lock_vld=0.
6. Reset mid-SEND. rst=1 with ld_rts=1 and ld_rtr=0 → the next cycle shows ld_rts=0, all ld_*=0, rr_ptr=0. With req_rts=1111 after reset, requester 0 wins first.
